// File: rtl/bullet_scheduler_pkg.sv
// bullet_scheduler_pkg: shared game types for the bullet pool -- directions,
// FSM states, colour codes, arena bounds and the {x, y} position packing.
package bullet_scheduler_pkg;
   localparam int ARENA_MIN = 0;
   localparam int ARENA_MAX = 255;
   typedef enum logic [1:0] {DIR_PX = 2'd0, DIR_NX = 2'd1, DIR_PY = 2'd2, DIR_NY = 2'd3} dir_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_UPDATE = 2'd1, S_STREAM = 2'd2} state_t;
   typedef enum logic [2:0] {
      COL_WHITE, COL_RED, COL_ORANGE, COL_YELLOW, COL_GREEN, COL_CYAN, COL_BLUE, COL_PURPLE
   } color_t;
   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
   } pos_t;
   typedef struct packed {
      pos_t   pos;
      color_t color;
      dir_t   dir;
   } slot_t;
   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return a >= b ? a - b : b - a;
   endfunction
endpackage

// File: rtl/bullet_scheduler_slot_update.sv
// bullet_slot_update: combinational move, bounds and collision unit, shared
// by all slots during UPDATE.
module bullet_slot_update
   import bullet_scheduler_pkg::*;
#(
   parameter int STEP  = 1,
   parameter int HIT_R = 4
) (
   input  pos_t i_pos,
   input  dir_t i_dir,
   input  pos_t i_player,
   output pos_t o_pos,
   output logic o_kill,
   output logic o_hit
);
   logic [8:0] w_x;
   logic [8:0] w_y;
   logic       w_oob;
   // 9-bit arithmetic exposes the carry/borrow that leaves the arena
   assign w_x = i_dir == DIR_PX ? {1'b0, i_pos.x} + 9'(STEP) :
                i_dir == DIR_NX ? {1'b0, i_pos.x} - 9'(STEP) : {1'b0, i_pos.x};
   assign w_y = i_dir == DIR_PY ? {1'b0, i_pos.y} + 9'(STEP) :
                i_dir == DIR_NY ? {1'b0, i_pos.y} - 9'(STEP) : {1'b0, i_pos.y};
   assign w_oob = w_x > 9'(ARENA_MAX) || w_y > 9'(ARENA_MAX);
   assign o_pos = '{x: w_x[7:0], y: w_y[7:0]};
   assign o_hit = !w_oob && abs_diff(w_x[7:0], i_player.x) <= 8'(HIT_R)
                         && abs_diff(w_y[7:0], i_player.y) <= 8'(HIT_R);
   assign o_kill = w_oob || o_hit;
endmodule

// File: rtl/bullet_scheduler.sv
// bullet_scheduler: slot pool of moving bullets; spawns into the lowest free
// slot, moves/collides one slot per cycle on a tick, and streams live slots.
module bullet_scheduler
   import bullet_scheduler_pkg::*;
#(
   parameter int NUM_SLOTS = 8,
   parameter int HIT_R     = 4,
   parameter int STEP      = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        enable,
   input  logic        spawn_req,
   input  logic [15:0] spawn_pos,
   input  logic [2:0]  spawn_color,
   input  logic [1:0]  spawn_dir,
   input  logic [15:0] player_pos,
   input  logic        render_ready,
   output logic        spawn_ack,
   output logic        bullet_valid,
   output logic [15:0] bullet_pos,
   output logic [2:0]  bullet_color,
   output logic [2:0]  bullet_index,
   output logic        hit,
   output logic [3:0]  active_count
);
   localparam int IW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
   localparam logic [IW-1:0] LAST = IW'(NUM_SLOTS - 1);

   state_t                 r_state;
   logic [IW-1:0]          r_ptr;
   logic                   r_tick_pend;
   slot_t                  r_slot [NUM_SLOTS];
   logic [NUM_SLOTS-1:0]   r_live;
   logic                   r_spawn_ack;
   logic                   r_hit;
   logic                   r_valid;
   pos_t                   r_bpos;
   logic [2:0]             r_bcol;
   logic [2:0]             r_bidx;
   logic [3:0]             r_count;
   logic                   w_go;
   logic                   w_free_any;
   logic                   w_nxt_any;
   logic [IW-1:0]          w_free_idx;
   logic [IW-1:0]          w_nxt_idx;
   pos_t                   w_new_pos;
   logic                   w_kill;
   logic                   w_hit;

   assign w_go = enable && (tick || r_tick_pend);

   // lowest free slot, and lowest live slot at or above the stream pointer
   always_comb begin
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_nxt_any  = 1'b0;
      w_nxt_idx  = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (!r_live[i]) begin
            w_free_any = 1'b1;
            w_free_idx = IW'(i);
         end
         if (r_live[i] && IW'(i) >= r_ptr) begin
            w_nxt_any = 1'b1;
            w_nxt_idx = IW'(i);
         end
      end
   end

   bullet_slot_update #(.STEP(STEP), .HIT_R(HIT_R)) u_update (
      .i_pos   (r_slot[r_ptr].pos),
      .i_dir   (r_slot[r_ptr].dir),
      .i_player(pos_t'(player_pos)),
      .o_pos   (w_new_pos),
      .o_kill  (w_kill),
      .o_hit   (w_hit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_tick_pend <= 1'b0;
         r_live      <= '0;
         r_spawn_ack <= 1'b0;
         r_hit       <= 1'b0;
         r_valid     <= 1'b0;
         r_bpos      <= '0;
         r_bcol      <= '0;
         r_bidx      <= '0;
         r_count     <= '0;
      end else begin
         r_spawn_ack <= 1'b0;
         r_hit       <= 1'b0;
         r_tick_pend <= enable && (r_tick_pend || tick);
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state     <= S_UPDATE;
                  r_ptr       <= '0;
                  r_tick_pend <= r_tick_pend && tick;
               end else if (spawn_req && enable && w_free_any && !r_spawn_ack) begin
                  // the guard on r_spawn_ack ignores a request still held during its own ack
                  r_live[w_free_idx] <= 1'b1;
                  r_slot[w_free_idx] <= '{pos: pos_t'(spawn_pos), color: color_t'(spawn_color), dir: dir_t'(spawn_dir)};
                  r_spawn_ack        <= 1'b1;
                  r_count            <= r_count + 1'b1;
               end else if (|r_live) begin
                  r_state <= S_STREAM;
                  r_ptr   <= '0;
               end
            end
            S_UPDATE: begin
               if (enable && r_live[r_ptr]) begin
                  r_slot[r_ptr].pos <= w_new_pos;
                  r_hit             <= w_hit;
                  if (w_kill) begin
                     r_live[r_ptr] <= 1'b0;
                     r_count       <= r_count - 1'b1;
                  end
               end
               r_ptr <= r_ptr + 1'b1;
               if (r_ptr == LAST) r_state <= S_IDLE;
            end
            S_STREAM: begin
               if (r_valid) begin
                  if (render_ready) begin
                     r_valid <= 1'b0;
                     if (w_go) begin
                        r_state     <= S_UPDATE;
                        r_ptr       <= '0;
                        r_tick_pend <= r_tick_pend && tick;
                     end else if (r_ptr == LAST) r_state <= S_IDLE;
                     else r_ptr <= r_ptr + 1'b1;
                  end
               end else if (w_go) begin
                  r_state     <= S_UPDATE;
                  r_ptr       <= '0;
                  r_tick_pend <= r_tick_pend && tick;
               end else if (w_nxt_any) begin
                  r_valid <= 1'b1;
                  r_ptr   <= w_nxt_idx;
                  r_bpos  <= r_slot[w_nxt_idx].pos;
                  r_bcol  <= r_slot[w_nxt_idx].color;
                  r_bidx  <= 3'(w_nxt_idx);
               end else r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign spawn_ack    = r_spawn_ack;
   assign hit          = r_hit;
   assign bullet_valid = r_valid;
   assign bullet_pos   = r_bpos;
   assign bullet_color = r_bcol;
   assign bullet_index = r_bidx;
   assign active_count = r_count;
endmodule

// File: tb/tb_bullet_scheduler.sv
// tb_bullet_scheduler: table-driven single-bullet vectors, directed corner
// sequences, and a randomized run against a slot-pool reference model.
module tb_bullet_scheduler;
   localparam int STEP  = 1;
   localparam int HIT_R = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        enable = 1'b1;
   logic        spawn_req = 1'b0;
   logic [15:0] spawn_pos = '0;
   logic [2:0]  spawn_color = '0;
   logic [1:0]  spawn_dir = '0;
   logic [15:0] player_pos = '0;
   logic        render_ready = 1'b1;
   logic        spawn_ack, bullet_valid, hit;
   logic [15:0] bullet_pos;
   logic [2:0]  bullet_color, bullet_index;
   logic [3:0]  active_count;

   bullet_scheduler #(.NUM_SLOTS(8), .HIT_R(HIT_R), .STEP(STEP)) dut (
      .clk(clk), .reset(reset), .tick(tick), .enable(enable),
      .spawn_req(spawn_req), .spawn_pos(spawn_pos), .spawn_color(spawn_color),
      .spawn_dir(spawn_dir), .player_pos(player_pos), .render_ready(render_ready),
      .spawn_ack(spawn_ack), .bullet_valid(bullet_valid), .bullet_pos(bullet_pos),
      .bullet_color(bullet_color), .bullet_index(bullet_index), .hit(hit),
      .active_count(active_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int hit_cnt = 0;
   int ack_cnt = 0;
   bit rnd_rdy = 1'b0;
   logic        seen [8];
   logic [15:0] spos [8];
   logic [2:0]  scol [8];

   // reference pool: positions as plain integers so leaving 0..255 is visible
   bit ml [8];
   int mx [8], my [8], md [8], mc [8];

   typedef struct {
      logic [15:0] pos;
      logic [2:0]  col;
      logic [1:0]  dir;
      logic [15:0] ply;
      int          nt;
      bit          live;
      logic [15:0] epos;
      int          hits;
   } vec_t;
   vec_t tv [11];

   always @(negedge clk) begin
      if (bullet_valid && render_ready) begin
         seen[bullet_index] = 1'b1;
         spos[bullet_index] = bullet_pos;
         scol[bullet_index] = bullet_color;
      end
      if (hit) hit_cnt++;
      if (spawn_ack) ack_cnt++;
   end

   initial forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) render_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      spawn_req = 1'b0;
      tick = 1'b0;
      cyc();
      cyc();
      chk("rst_valid", bullet_valid, 0);
      chk("rst_pos", bullet_pos, 0);
      chk("rst_color", bullet_color, 0);
      chk("rst_index", bullet_index, 0);
      chk("rst_ack", spawn_ack, 0);
      chk("rst_hit", hit, 0);
      chk("rst_count", active_count, 0);
      reset = 1'b0;
      for (int i = 0; i < 8; i++) ml[i] = 1'b0;
   endtask

   task automatic spawn(input logic [15:0] p, input logic [2:0] c, input logic [1:0] d, output int lat);
      spawn_pos = p;
      spawn_color = c;
      spawn_dir = d;
      spawn_req = 1'b1;
      lat = 0;
      for (int k = 1; k <= 80 && lat == 0; k++) begin
         cyc();
         if (spawn_ack) lat = k;
      end
      spawn_req = 1'b0;
      chk("spawn_acked", 32'(lat != 0), 1);
      cyc();
      chk("ack_one_cycle", spawn_ack, 0);
   endtask

   task automatic do_tick();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      repeat (40) cyc();
   endtask

   task automatic snap(input int n);
      for (int i = 0; i < 8; i++) seen[i] = 1'b0;
      repeat (n) cyc();
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += int'(ml[i]);
      return n;
   endfunction

   function automatic void m_spawn(input logic [15:0] p, input int c, input int d);
      for (int i = 0; i < 8; i++)
         if (!ml[i]) begin
            ml[i] = 1'b1; mx[i] = int'(p[15:8]); my[i] = int'(p[7:0]); mc[i] = c; md[i] = d;
            return;
         end
   endfunction

   function automatic int m_tick(input logic [15:0] ply);
      int h = 0;
      int px = int'(ply[15:8]);
      int py = int'(ply[7:0]);
      for (int i = 0; i < 8; i++)
         if (ml[i]) begin
            mx[i] += md[i] == 0 ? STEP : md[i] == 1 ? -STEP : 0;
            my[i] += md[i] == 2 ? STEP : md[i] == 3 ? -STEP : 0;
            if (mx[i] < 0 || mx[i] > 255 || my[i] < 0 || my[i] > 255) ml[i] = 1'b0;
            else if ((mx[i] > px ? mx[i] - px : px - mx[i]) <= HIT_R &&
                     (my[i] > py ? my[i] - py : py - my[i]) <= HIT_R) begin
               ml[i] = 1'b0;
               h++;
            end
         end
      return h;
   endfunction

   task automatic model_stream_check();
      snap(150);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("rnd_seen%0d", i), 32'(seen[i]), 32'(ml[i]));
         if (ml[i]) begin
            chk($sformatf("rnd_pos%0d", i), spos[i], 32'(mx[i] * 256 + my[i]));
            chk($sformatf("rnd_col%0d", i), scol[i], 32'(mc[i]));
         end
      end
   endtask

   initial begin
      int lat, h0, a0, hm;
      bit en, got;
      tv[0]  = '{16'h1010, 3'd3, 2'd0, 16'h8080, 5, 1'b1, 16'h1510, 0};
      tv[1]  = '{16'h1010, 3'd1, 2'd1, 16'h8080, 5, 1'b1, 16'h0B10, 0};
      tv[2]  = '{16'h1010, 3'd2, 2'd2, 16'h8080, 5, 1'b1, 16'h1015, 0};
      tv[3]  = '{16'h1010, 3'd4, 2'd3, 16'h8080, 5, 1'b1, 16'h100B, 0};
      tv[4]  = '{16'hFE20, 3'd5, 2'd0, 16'h8080, 2, 1'b0, 16'h0000, 0};
      tv[5]  = '{16'h0120, 3'd6, 2'd1, 16'h8080, 2, 1'b0, 16'h0000, 0};
      tv[6]  = '{16'h20FF, 3'd7, 2'd2, 16'h8080, 1, 1'b0, 16'h0000, 0};
      tv[7]  = '{16'h3A40, 3'd1, 2'd0, 16'h4040, 2, 1'b0, 16'h0000, 1};
      tv[8]  = '{16'h4445, 3'd2, 2'd3, 16'h4040, 1, 1'b0, 16'h0000, 1};
      tv[9]  = '{16'h4546, 3'd3, 2'd3, 16'h4040, 1, 1'b1, 16'h4545, 0};
      tv[10] = '{16'h3B40, 3'd0, 2'd0, 16'h4040, 0, 1'b1, 16'h3B40, 0};

      for (int v = 0; v < 11; v++) begin
         do_reset();
         player_pos = tv[v].ply;
         spawn(tv[v].pos, tv[v].col, tv[v].dir, lat);
         chk($sformatf("v%0d_ack_latency", v), 32'(lat), 1);
         chk($sformatf("v%0d_count_spawn", v), active_count, 1);
         h0 = hit_cnt;
         for (int t = 0; t < tv[v].nt; t++) do_tick();
         chk($sformatf("v%0d_hits", v), 32'(hit_cnt - h0), 32'(tv[v].hits));
         chk($sformatf("v%0d_count", v), active_count, 32'(tv[v].live));
         snap(40);
         chk($sformatf("v%0d_seen", v), 32'(seen[0]), 32'(tv[v].live));
         if (tv[v].live) begin
            chk($sformatf("v%0d_pos", v), spos[0], tv[v].epos);
            chk($sformatf("v%0d_col", v), scol[0], tv[v].col);
         end
      end

      // full pool: the 9th request waits, then lands in the slot freed by slot 3 leaving the arena
      do_reset();
      player_pos = 16'h0000;
      for (int i = 0; i < 8; i++)
         spawn(i == 3 ? 16'h50FF : {8'(8'h20 + i * 16), 8'h10}, 3'(i), 2'd2, lat);
      chk("full_count", active_count, 8);
      spawn_pos = 16'h9090; spawn_color = 3'd5; spawn_dir = 2'd0; spawn_req = 1'b1;
      a0 = ack_cnt;
      repeat (30) cyc();
      chk("full_no_ack", 32'(ack_cnt - a0), 0);
      chk("full_count_hold", active_count, 8);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 80 && !got; k++) begin
         cyc();
         if (spawn_ack) got = 1'b1;
      end
      spawn_req = 1'b0;
      chk("full_late_ack", 32'(got), 1);
      repeat (5) cyc();
      chk("full_count_after", active_count, 8);
      snap(60);
      chk("full_slot3_seen", 32'(seen[3]), 1);
      chk("full_slot3_pos", spos[3], 16'h9090);
      chk("full_slot3_col", scol[3], 5);
      chk("full_slot0_pos", spos[0], 16'h2011);

      // back-pressure: presented bullet held stable while a tick waits behind it
      do_reset();
      player_pos = 16'h0000;
      spawn(16'h5050, 3'd2, 2'd0, lat);
      spawn(16'h6060, 3'd4, 2'd2, lat);
      render_ready = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         cyc();
         if (bullet_valid) got = 1'b1;
      end
      chk("bp_valid_seen", 32'(got), 1);
      for (int k = 0; k < 10; k++) begin
         tick = (k == 3);
         cyc();
         chk("bp_valid", bullet_valid, 1);
         chk("bp_pos", bullet_pos, 16'h5050);
         chk("bp_index", bullet_index, 0);
         chk("bp_color", bullet_color, 2);
      end
      tick = 1'b0;
      render_ready = 1'b1;
      repeat (40) cyc();
      snap(60);
      chk("bp_slot0_moved", spos[0], 16'h5150);
      chk("bp_slot1_moved", spos[1], 16'h6061);

      // enable low: bullets stream but stay frozen, ticks and spawns ignored
      do_reset();
      player_pos = 16'hC0C0;
      spawn(16'h3030, 3'd1, 2'd0, lat);
      enable = 1'b0;
      do_tick();
      chk("dis_count", active_count, 1);
      snap(40);
      chk("dis_seen", 32'(seen[0]), 1);
      chk("dis_pos", spos[0], 16'h3030);
      a0 = ack_cnt;
      spawn_pos = 16'h7070; spawn_req = 1'b1;
      repeat (20) cyc();
      spawn_req = 1'b0;
      chk("dis_no_ack", 32'(ack_cnt - a0), 0);
      enable = 1'b1;
      do_tick();
      snap(40);
      chk("en_pos", spos[0], 16'h3130);

      // reset in the middle of an UPDATE whose last slot would collide
      do_reset();
      player_pos = 16'h4040;
      for (int i = 0; i < 8; i++)
         spawn(i == 7 ? 16'h3B40 : {8'(8'h10 + i * 4), 8'h10}, 3'd1, i == 7 ? 2'd0 : 2'd2, lat);
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         cyc();
         if (bullet_valid && bullet_index == 3'd7) got = 1'b1;
      end
      chk("mid_found_last", 32'(got), 1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      cyc();
      do_reset();
      h0 = hit_cnt;
      a0 = ack_cnt;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (bullet_valid) got = 1'b1;
      end
      chk("mid_no_hit", 32'(hit_cnt - h0), 0);
      chk("mid_no_ack", 32'(ack_cnt - a0), 0);
      chk("mid_no_valid", 32'(got), 0);
      chk("mid_count", active_count, 0);

      // randomized run against the reference pool
      do_reset();
      rnd_rdy = 1'b1;
      player_pos = {8'($urandom_range(32, 224)), 8'($urandom_range(32, 224))};
      for (int it = 0; it < 48; it++) begin
         int r;
         logic [15:0] p;
         r = $urandom_range(0, 2);
         if (r == 0 && m_count() < 8) begin
            p = $urandom_range(0, 1) ? 16'($urandom) :
                {8'(int'(player_pos[15:8]) + $urandom_range(0, 16) - 8),
                 8'(int'(player_pos[7:0]) + $urandom_range(0, 16) - 8)};
            r = $urandom_range(0, 7);
            hm = $urandom_range(0, 3);
            spawn(p, 3'(r), 2'(hm), lat);
            m_spawn(p, r, hm);
            chk("rnd_count_spawn", active_count, 32'(m_count()));
         end else begin
            en = $urandom_range(0, 3) != 0;
            enable = en;
            h0 = hit_cnt;
            do_tick();
            enable = 1'b1;
            hm = en ? m_tick(player_pos) : 0;
            chk("rnd_hits", 32'(hit_cnt - h0), 32'(hm));
            chk("rnd_count_tick", active_count, 32'(m_count()));
         end
         if (it % 12 == 11) model_stream_check();
      end
      rnd_rdy = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bullet_scheduler.md
BULLET_SCHEDULER -- requirements
Module: bullet_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning the number of bullet slots in the pool.
REQ-002 SHALL have parameter HIT_R, default 4, meaning the half-width in pixels of the player hit box.
REQ-003 SHALL have parameter STEP, default 1, meaning the pixels moved per game tick.
REQ-004 clk  in  1  system clock; the block uses one clock, and reset is synchronous and active-high.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 tick  in  1  one-cycle game-tick pulse (10 Hz domain, already synchronised to clk).
REQ-007 enable  in  1  battle phase active; when low, no spawn, move or hit occurs.
REQ-008 spawn_req  in  1  spawn request; held until spawn_ack.
REQ-009 spawn_pos  in  16  {x[15:8], y[7:0]} start position.
REQ-010 spawn_color  in  3  bullet colour code.
REQ-011 spawn_dir  in  2  direction: 0 = +x, 1 = -x, 2 = +y, 3 = -y.
REQ-012 player_pos  in  16  {x, y} of the player heart.
REQ-013 render_ready  in  1  the renderer accepts the presented bullet.
REQ-014 spawn_ack  out  1  one-cycle pulse when a request is accepted.
REQ-015 bullet_valid  out  1  bullet_pos, bullet_color and bullet_index are valid.
REQ-016 bullet_pos  out  16  position of the presented bullet.
REQ-017 bullet_color  out  3  colour of the presented bullet.
REQ-018 bullet_index  out  3  slot number of the presented bullet.
REQ-019 hit  out  1  one-cycle pulse per collision detected.
REQ-020 active_count  out  4  number of live slots.

Function
REQ-021 The FSM SHALL have the states IDLE, UPDATE and STREAM, with one state register.
REQ-022 IDLE, transitions by priority:
- tick && enable -> UPDATE (slot pointer = 0);
- else spawn_req && enable && a free slot exists -> write the lowest free slot, pulse spawn_ack next cycle, stay in IDLE;
- else, if any slot is live -> STREAM (pointer = 0).
REQ-023 With no free slot, a spawn_req SHALL remain pending with no ack and no overwrite.
REQ-024 UPDATE SHALL process one slot per cycle (NUM_SLOTS cycles in total), then return to IDLE.
- live slot: move STEP in its direction using 9-bit arithmetic;
- any carry or borrow out of 0..255 SHALL kill the slot (no wrap-around).
REQ-025 Collision SHALL be tested on the updated position: |bx-px| <= HIT_R and |by-py| <= HIT_R -> pulse hit for one cycle and kill the slot.
- Multiple hits in one UPDATE SHALL produce multiple separate hit pulses.
REQ-026 STREAM SHALL scan from the pointer to the next live slot and present it with bullet_valid = 1.
- Outputs SHALL be held stable until render_ready.
- Transfer occurs when bullet_valid && render_ready; the pointer then advances.
- After the last slot, return to IDLE.
REQ-027 A tick arriving during STREAM SHALL abort STREAM after any in-progress transfer completes, then enter UPDATE.
- The tick SHALL be latched in tick_pend and SHALL never be lost.
- A tick during UPDATE SHALL likewise set tick_pend.
REQ-028 When enable is low, the FSM SHALL still STREAM existing bullets, but ticks are discarded and slots are frozen.
REQ-029 active_count SHALL update in the cycle after every spawn or kill.
REQ-030 bullet_valid SHALL be 0 outside STREAM.

Reset
REQ-031 While reset is high, at the next clk edge:
- state = IDLE, all slots dead, pointer = 0, tick_pend = 0;
- spawn_ack = 0, hit = 0, bullet_valid = 0, bullet_pos = 0, bullet_color = 0, bullet_index = 0, active_count = 0.
REQ-032 A reset mid-UPDATE or mid-STREAM SHALL abandon the operation, with no ack or hit pulse afterwards.

Structure
REQ-033 A shared game package SHALL hold:
- the direction encodings, the FSM state encodings and the colour codes;
- the arena bounds (0..255) and the pos packing {x, y}.
REQ-034 One sub-module, bullet_slot_update, SHALL be the combinational move/bounds/collision unit, instantiated once and time-shared across slots.

Verification
REQ-035 Reset, then spawn (0x1010, colour 3, dir 0): spawn_ack one cycle later, active_count = 1; after 5 ticks the stream shows bullet_pos = 0x1510.
REQ-036 Fill 8 slots, then a 9th spawn_req: no ack while full; after one slot is killed, the 9th is acked into that slot index.
REQ-037 Bullet at 0xFE20, dir 0: after 2 ticks it is killed (x = 256 is out of range), active_count decrements, and no wrap to 0x0020 appears.
REQ-038 player_pos = 0x4040, bullet at 0x3B40, dir 0: hit pulses exactly once on the tick reaching x = 0x3C, and the slot is removed.
REQ-039 render_ready held low for 10 cycles during STREAM: outputs stay stable; a tick arriving meanwhile is serviced after the transfer completes, and no tick is lost.
REQ-040 Assert reset mid-UPDATE: the next cycle shows all outputs 0 and state IDLE.
